keycode_report_bank: RTL and testbench

Parametrised keyboard-report register bank. It sits between the Nios II Avalon-MM fabric and the game logic, and replaces fixed per-key 8-bit export PIOs with NUM_KEYS keycode channels. Software fills a shadow bank and commits it atomically. The block outputs the committed set with a valid flag, per-channel new-press pulses, and a watchdog that clears all keys if software stops reporting (USB stall or unplug).

---
 rtl/keycode_report_bank_if.sv | 20 ++
 rtl/keycode_report_bank.sv | 160 ++++++++++++++++
 tb/tb_keycode_report_bank.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/keycode_report_bank_if.sv
// Avalon-MM slave bus for the keycode report bank: word address, write, read, registered read data.
interface keycode_report_bank_if #(
  parameter int unsigned ADDR_W = 4
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/keycode_report_bank.sv
// Keyboard-report register bank: software fills a shadow bank, commits it atomically,
// and a watchdog clears the active keys when commits stop arriving.
module keycode_report_bank #(
  parameter int unsigned NUM_KEYS       = 6,
  parameter int unsigned KEY_W          = 8,
  parameter int unsigned ADDR_W         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic                      clk_clk,
  input  logic                      reset_reset_n,
  keycode_report_bank_if.slave      avs,
  output logic [NUM_KEYS*KEY_W-1:0] key_export,
  output logic                      key_valid,
  output logic [NUM_KEYS-1:0]       press_pulse
);

  localparam int unsigned       CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(NUM_KEYS);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [KEY_W-1:0]    r_shadow [NUM_KEYS];
  logic [KEY_W-1:0]    r_active [NUM_KEYS];
  logic                r_key_valid;
  logic                r_timeout_flag;
  logic [CNT_W-1:0]    r_cnt;
  logic [15:0]         r_commit_count;
  logic [NUM_KEYS-1:0] r_press;
  logic [31:0]         r_readdata;

  logic                w_ctrl_wr;
  logic                w_commit;
  logic                w_clr_shadow;
  logic                w_clr_flag;
  logic                w_expire;
  logic [NUM_KEYS-1:0] w_shadow_we;
  logic [NUM_KEYS-1:0] w_hit;
  logic [NUM_KEYS-1:0] w_press;
  logic [31:0]         w_rdata;
  logic                w_unused_wdata;

  assign w_unused_wdata = ^avs.avs_writedata;

  assign w_ctrl_wr    = avs.avs_write && (avs.avs_address == CTRL_ADDR);
  assign w_commit     = w_ctrl_wr && avs.avs_writedata[0];
  assign w_clr_shadow = w_ctrl_wr && avs.avs_writedata[1];
  assign w_clr_flag   = w_ctrl_wr && avs.avs_writedata[2];
  // A commit landing in the expiry cycle suppresses the timeout.
  assign w_expire     = r_key_valid && !w_commit && (r_cnt == CNT_LAST);

  // Address decode for shadow writes and the read-data mux.
  always_comb begin
    w_shadow_we = '0;
    w_rdata     = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      w_shadow_we[i] = avs.avs_write && (avs.avs_address == ADDR_W'(i));
      if (avs.avs_address == ADDR_W'(i)) begin
        w_rdata = 32'(r_shadow[i]);
      end
    end
    if (avs.avs_address == CTRL_ADDR) begin
      w_rdata = {r_commit_count, 14'd0, r_timeout_flag, r_key_valid};
    end
  end

  // New-press detection: nonzero shadow codes absent from the pre-commit active set.
  always_comb begin
    w_hit   = '0;
    w_press = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      for (int unsigned j = 0; j < NUM_KEYS; j++) begin
        if (r_shadow[i] == r_active[j]) begin
          w_hit[i] = 1'b1;
        end
      end
      w_press[i] = (r_shadow[i] != '0) && !w_hit[i];
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        r_shadow[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (w_clr_shadow) begin
          r_shadow[i] <= '0;
        end else if (w_shadow_we[i]) begin
          r_shadow[i] <= avs.avs_writedata[KEY_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        r_active[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_KEYS; i++) begin
        if (w_commit) begin
          r_active[i] <= r_shadow[i];
        end else if (w_expire) begin
          r_active[i] <= '0;
        end
      end
    end
  end

  // Commit, watchdog and status state.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_key_valid    <= 1'b0;
      r_timeout_flag <= 1'b0;
      r_cnt          <= '0;
      r_commit_count <= '0;
      r_press        <= '0;
    end else begin
      r_press <= w_commit ? w_press : '0;
      if (w_commit) begin
        r_key_valid    <= 1'b1;
        r_cnt          <= '0;
        r_commit_count <= r_commit_count + 16'd1;
      end else if (w_expire) begin
        r_key_valid <= 1'b0;
        r_cnt       <= '0;
      end else if (r_key_valid) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (w_expire) begin
        r_timeout_flag <= 1'b1;
      end else if (w_clr_flag) begin
        r_timeout_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_readdata <= '0;
    end else if (avs.avs_read) begin
      r_readdata <= w_rdata;
    end
  end

  always_comb begin
    key_export = '0;
    for (int unsigned i = 0; i < NUM_KEYS; i++) begin
      key_export[i*KEY_W +: KEY_W] = r_active[i];
    end
  end

  assign key_valid        = r_key_valid;
  assign press_pulse      = r_press;
  assign avs.avs_readdata = r_readdata;

endmodule

// File: tb/tb_keycode_report_bank.sv
// Scoreboarded random/directed bench for keycode_report_bank against a cycle-indexed reference model.
module tb_keycode_report_bank;
  localparam int NK = 6;
  localparam int KW = 8;
  localparam int AW = 4;
  localparam int TO = 16;

  typedef struct {
    logic [31:0]      rdata;
    logic [NK*KW-1:0] exp;
    logic             valid;
    logic [NK-1:0]    press;
  } exp_t;

  logic             clk;
  logic             reset_reset_n;
  logic [NK*KW-1:0] key_export;
  logic             key_valid;
  logic [NK-1:0]    press_pulse;

  keycode_report_bank_if #(.ADDR_W(AW)) bus ();

  keycode_report_bank #(
    .NUM_KEYS(NK), .KEY_W(KW), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_clk(clk),
    .reset_reset_n(reset_reset_n),
    .avs(bus),
    .key_export(key_export),
    .key_valid(key_valid),
    .press_pulse(press_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t q[$];

  // reference model state
  int unsigned m_shadow [NK];
  int unsigned m_active [NK];
  bit          m_valid;
  bit          m_tflag;
  int          m_cyc;
  int          m_last;
  logic [15:0] m_cc;
  logic [31:0] m_rd;
  logic [NK-1:0] m_press;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: actual=%h expected=%h", nm, $time, act, expv);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NK; i++) begin
      m_shadow[i] = 0;
      m_active[i] = 0;
    end
    m_valid = 0; m_tflag = 0; m_cc = '0; m_rd = '0; m_press = '0;
    m_last = 0; m_cyc = 0;
  endtask

  // Advance the model by one clock edge given this cycle's bus inputs.
  task automatic m_edge(input int addr, input bit wr, input logic [31:0] wd, input bit rd);
    bit commit, clr_sh, clr_f, expire, found;
    commit = wr && addr == NK && wd[0];
    clr_sh = wr && addr == NK && wd[1];
    clr_f  = wr && addr == NK && wd[2];
    if (rd) begin
      if (addr < NK)       m_rd = 32'(m_shadow[addr]);
      else if (addr == NK) m_rd = {m_cc, 14'd0, m_tflag, m_valid};
      else                 m_rd = '0;
    end
    m_press = '0;
    if (commit) begin
      for (int i = 0; i < NK; i++) begin
        found = 0;
        foreach (m_active[j]) if (m_active[j] == m_shadow[i]) found = 1;
        m_press[i] = (m_shadow[i] != 0) && !found;
      end
    end
    expire = m_valid && !commit && (m_cyc - m_last == TO);
    if (commit) begin
      foreach (m_active[i]) m_active[i] = m_shadow[i];
      m_valid = 1;
      m_last  = m_cyc;
      m_cc    = m_cc + 16'd1;
    end else if (expire) begin
      foreach (m_active[i]) m_active[i] = 0;
      m_valid = 0;
    end
    if (clr_f)  m_tflag = 0;
    if (expire) m_tflag = 1;
    if (clr_sh) foreach (m_shadow[i]) m_shadow[i] = 0;
    else if (wr && addr < NK) m_shadow[addr] = int'(wd[KW-1:0]);
    m_cyc++;
  endtask

  task automatic step(input int addr, input bit wr, input logic [31:0] wd, input bit rd);
    exp_t e;
    @(negedge clk);
    bus.avs_address   = AW'(addr);
    bus.avs_write     = wr;
    bus.avs_writedata = wd;
    bus.avs_read      = rd;
    m_edge(addr, wr, wd, rd);
    e.rdata = m_rd;
    e.valid = m_valid;
    e.press = m_press;
    e.exp   = '0;
    for (int i = 0; i < NK; i++) e.exp[i*KW +: KW] = KW'(m_active[i]);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 32'd0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_readdata"}, 64'(bus.avs_readdata), 64'd0);
    chk({tag, "_export"},   64'(key_export),       64'd0);
    chk({tag, "_valid"},    64'(key_valid),        64'd0);
    chk({tag, "_press"},    64'(press_pulse),      64'd0);
  endtask

  // Monitor: compares DUT outputs after each edge with the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("readdata",    64'(bus.avs_readdata), 64'(e.rdata));
        chk("key_export",  64'(key_export),       64'(e.exp));
        chk("key_valid",   64'(key_valid),        64'(e.valid));
        chk("press_pulse", 64'(press_pulse),      64'(e.press));
      end
    end
  end

  initial begin
    int r, a, g;
    m_reset();
    reset_reset_n     = 1'b0;
    bus.avs_address   = '0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("por");
    @(negedge clk);
    reset_reset_n = 1'b1;

    // defaults, first commit and press detection
    step(NK, 0, 32'd0, 1);
    step(0, 1, 32'h04, 0);
    step(1, 1, 32'h1A, 0);
    step(NK, 1, 32'h1, 0);
    step(NK, 0, 32'd0, 1);
    step(0, 1, 32'h1A, 0);
    step(1, 1, 32'h16, 0);
    step(NK, 1, 32'h1, 0);
    step(NK, 0, 32'd0, 1);

    // watchdog expiry, then flag clear
    idle(20);
    step(NK, 0, 32'd0, 1);
    step(NK, 1, 32'h4, 0);
    step(NK, 0, 32'd0, 1);

    // commit in the expiry cycle, then commit with shadow clear
    step(NK, 1, 32'h1, 0);
    idle(TO - 1);
    step(NK, 1, 32'h1, 0);
    step(NK, 0, 32'd0, 1);
    step(2, 1, 32'h55, 0);
    step(NK, 1, 32'h3, 0);
    step(0, 0, 32'd0, 1);
    step(2, 0, 32'd0, 1);
    step(NK, 0, 32'd0, 1);

    // out-of-range address
    step(7, 1, 32'hFFFF_FFFF, 0);
    step(7, 0, 32'd0, 1);
    step(15, 0, 32'd0, 1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 40) begin
        a = int'($urandom_range(0, NK - 1));
        step(a, 1, {24'($urandom()), 8'($urandom_range(0, 6))}, $urandom_range(0, 3) == 0);
      end else if (r < 52) begin
        step(NK, 1, {$urandom()} & 32'hFFFF_FFF8 | 32'h1, $urandom_range(0, 1) == 1);
      end else if (r < 60) begin
        step(NK, 1, 32'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
      end else if (r < 64) begin
        step(int'($urandom_range(NK + 1, 15)), 1, $urandom(), 1);
      end else if (r < 66) begin
        idle(TO + 2);
      end else begin
        step(int'($urandom_range(0, 15)), 0, 32'd0, $urandom_range(0, 1) == 1);
      end
    end

    // asynchronous reset during a press pulse
    step(0, 1, 32'h33, 0);
    step(NK, 1, 32'h1, 1);
    @(posedge clk);
    #3;
    bus.avs_write = 1'b0;
    bus.avs_read  = 1'b0;
    reset_reset_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst_hold");
    @(negedge clk);
    reset_reset_n = 1'b1;
    step(NK, 0, 32'd0, 1);
    step(0, 0, 32'd0, 1);
    idle(3);

    g = 0;
    while (q.size() != 0 && g < 10) begin
      @(posedge clk);
      g++;
    end
    #5;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: actual=%0d expected=0 pending", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
